seg7_scan_ctrl: RTL and testbench

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

---
 rtl/seg7_pkg.sv | 15 +
 rtl/seg7_hex_decode.sv | 12 +
 rtl/seg7_scan_ctrl.sv | 148 ++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan controller.
// Segment order is a..g on bits 6..0.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Entry n is the glyph for hex digit n.
  localparam logic [15:0][6:0] SEG_HEX = {
    7'b1000111, 7'b1001111, 7'b0111101, 7'b1001110,
    7'b0011111, 7'b1110111, 7'b1111011, 7'b1111111,
    7'b1110000, 7'b1011111, 7'b1011011, 7'b0110011,
    7'b1111001, 7'b1101101, 7'b0110000, 7'b1111110
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to seven-segment glyph lookup.
// Output is active-high; polarity is applied by the caller.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_HEX[nib_i];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scanner with a one-deep pending
// register that is committed to the display only at frame end.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 32,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  input  logic                    load_valid,
  output logic                    load_ready,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   digit_en
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int NW = 4 * NUM_DIGITS;

  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [6:0]    INV7     = {7{ACTIVE_LOW}};

  logic [DW-1:0]         div_q, div_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [NW-1:0]         disp_q, disp_d;
  logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d;
  logic                  disp_bl_q, disp_bl_d;
  logic [NW-1:0]         pend_q, pend_d;
  logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
  logic                  pend_bl_q, pend_bl_d;
  logic                  pend_full_q, pend_full_d;
  logic                  ready_q;
  logic [6:0]            seg_q;
  logic                  dp_q;
  logic [NUM_DIGITS-1:0] en_q;

  logic                  tc;
  logic                  fe;
  logic                  ld;
  logic [3:0]            nib;
  logic                  dp_sel;
  logic                  lz_sel;
  logic                  zh;
  logic                  blank;
  logic [NUM_DIGITS-1:0] en_d;
  logic [6:0]            hex_seg;
  logic [6:0]            seg_d;

  assign ld = load_valid & ready_q;

  always_comb begin
    tc = (div_q == DIV_LAST);
    fe = tc && (idx_q == IDX_LAST);
    div_d = tc ? '0 : div_q + 1'b1;
    idx_d = idx_q;
    if (tc) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    disp_d      = disp_q;
    disp_dp_d   = disp_dp_q;
    disp_bl_d   = disp_bl_q;
    pend_d      = pend_q;
    pend_dp_d   = pend_dp_q;
    pend_bl_d   = pend_bl_q;
    pend_full_d = pend_full_q;
    if (fe && pend_full_q) begin
      disp_d      = pend_q;
      disp_dp_d   = pend_dp_q;
      disp_bl_d   = pend_bl_q;
      pend_full_d = 1'b0;
    end
    if (ld) begin
      pend_d      = data_in;
      pend_dp_d   = dp_in;
      pend_bl_d   = blank_lz;
      pend_full_d = 1'b1;
    end
  end

  // zh accumulates "this nibble and all above are zero" from the top down.
  always_comb begin
    nib    = '0;
    dp_sel = 1'b0;
    lz_sel = 1'b0;
    en_d   = '0;
    zh     = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zh = zh & (disp_q[4*i +: 4] == 4'h0);
      if (idx_q == IW'(i)) begin
        nib     = disp_q[4*i +: 4];
        dp_sel  = disp_dp_q[i];
        lz_sel  = zh;
        en_d[i] = 1'b1;
      end
    end
  end

  seg7_hex_decode u_dec (
    .nib_i (nib),
    .seg_o (hex_seg)
  );

  assign blank = disp_bl_q && (idx_q != '0) && lz_sel;
  assign seg_d = (blank ? SEG_BLANK : hex_seg) ^ INV7;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q       <= '0;
      idx_q       <= '0;
      disp_q      <= '0;
      disp_dp_q   <= '0;
      disp_bl_q   <= 1'b0;
      pend_q      <= '0;
      pend_dp_q   <= '0;
      pend_bl_q   <= 1'b0;
      pend_full_q <= 1'b0;
      ready_q     <= 1'b0;
      seg_q       <= INV7;
      dp_q        <= ACTIVE_LOW;
      en_q        <= {NUM_DIGITS{ACTIVE_LOW}};
    end else begin
      div_q       <= div_d;
      idx_q       <= idx_d;
      disp_q      <= disp_d;
      disp_dp_q   <= disp_dp_d;
      disp_bl_q   <= disp_bl_d;
      pend_q      <= pend_d;
      pend_dp_q   <= pend_dp_d;
      pend_bl_q   <= pend_bl_d;
      pend_full_q <= pend_full_d;
      ready_q     <= ~pend_full_d;
      seg_q       <= seg_d;
      dp_q        <= dp_sel ^ ACTIVE_LOW;
      en_q        <= en_d ^ {NUM_DIGITS{ACTIVE_LOW}};
    end
  end

  assign load_ready = ready_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign digit_en   = en_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: a 4-digit active-high instance checked
// every cycle against a frame-arithmetic model, plus a 1-digit active-low one.
module tb_seg7_scan_ctrl;

  localparam int N = 4;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [15:0] data_in = '0;
  logic [3:0]  dp_in = '0;
  logic        blank_lz = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  digit_en;

  logic [3:0]  data1 = '0;
  logic [0:0]  dp1_in = '0;
  logic        bl1 = 1'b0;
  logic        valid1 = 1'b0;
  logic        ready1;
  logic [6:0]  seg1;
  logic        dp1;
  logic [0:0]  en1;

  int total = 0;
  int bad = 0;

  int          m;
  logic [15:0] mdisp, mpend;
  logic [3:0]  mdp, mpdp;
  logic        mbl, mpbl, mpf, mready;
  logic [6:0]  eseg;
  logic        edp;
  logic [3:0]  een;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.NUM_DIGITS(N), .SCAN_DIV(D), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .dp_in(dp_in),
    .blank_lz(blank_lz), .load_valid(load_valid),
    .load_ready(load_ready), .seg(seg), .dp(dp), .digit_en(digit_en)
  );

  seg7_scan_ctrl #(.NUM_DIGITS(1), .SCAN_DIV(D), .ACTIVE_LOW(1'b1)) dut1 (
    .clk(clk), .rst(rst), .data_in(data1), .dp_in(dp1_in),
    .blank_lz(bl1), .load_valid(valid1),
    .load_ready(ready1), .seg(seg1), .dp(dp1), .digit_en(en1)
  );

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1111110;
      4'h1: return 7'b0110000;
      4'h2: return 7'b1101101;
      4'h3: return 7'b1111001;
      4'h4: return 7'b0110011;
      4'h5: return 7'b1011011;
      4'h6: return 7'b1011111;
      4'h7: return 7'b1110000;
      4'h8: return 7'b1111111;
      4'h9: return 7'b1111011;
      4'hA: return 7'b1110111;
      4'hB: return 7'b0011111;
      4'hC: return 7'b1001110;
      4'hD: return 7'b0111101;
      4'hE: return 7'b1001111;
      default: return 7'b1000111;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input logic [15:0] v,
                                         input logic bl, input int i);
    logic [15:0] hi;
    hi = v >> (4 * i);
    if (bl && i > 0 && hi == 16'h0) return 7'b0000000;
    return hex7(hi[3:0]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: edge m after reset shows digit ((m-1)/D)%N; frame ends when m%(D*N)==0.
  task automatic step();
    int k;
    @(posedge clk);
    if (rst) begin
      m = 0; mdisp = '0; mdp = '0; mbl = 1'b0;
      mpend = '0; mpdp = '0; mpbl = 1'b0; mpf = 1'b0; mready = 1'b0;
      eseg = 7'b0; edp = 1'b0; een = 4'b0;
    end else begin
      m++;
      k = ((m - 1) / D) % N;
      eseg = exp_seg(mdisp, mbl, k);
      edp = mdp[k];
      een = 4'b0001 << k;
      if (m % (D * N) == 0 && mpf) begin
        mdisp = mpend; mdp = mpdp; mbl = mpbl; mpf = 1'b0;
      end
      if (load_valid && mready) begin
        mpend = data_in; mpdp = dp_in; mpbl = blank_lz; mpf = 1'b1;
      end
      mready = !mpf;
    end
    #1;
    chk("seg", seg, eseg);
    chk("dp", dp, edp);
    chk("digit_en", digit_en, een);
    chk("load_ready", load_ready, mready);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d,
                         input logic bl);
    bit got;
    got = 0;
    data_in = v; dp_in = d; blank_lz = bl; load_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (load_ready) begin
        step();
        got = 1;
        break;
      end
      step();
    end
    load_valid = 1'b0;
    chk("load_accept", got, 1);
  endtask

  task automatic read_frame(input string tag, input logic [27:0] es,
                            input logic [3:0] edps);
    logic [3:0] prev;
    bit found;
    found = 0;
    prev = digit_en;
    for (int c = 0; c < 40; c++) begin
      step();
      if (digit_en == 4'b0001 && prev == 4'b1000) begin
        found = 1;
        break;
      end
      prev = digit_en;
    end
    chk({tag, "_sync"}, found, 1);
    if (found) begin
      for (int d = 0; d < N; d++) begin
        chk({tag, "_seg"}, seg, es[7*d +: 7]);
        chk({tag, "_dp"}, dp, edps[d]);
        repeat (D) step();
      end
    end
  endtask

  initial begin
    int last, per1, per2, rises;
    logic pr;
    bit got1;

    repeat (3) step();
    chk("rst_seg", seg, 7'b0000000);
    chk("rst_en", digit_en, 4'b0000);
    chk("rst_ready", load_ready, 1'b0);
    chk("n1_rst_seg", seg1, 7'b1111111);
    chk("n1_rst_dp", dp1, 1'b1);
    chk("n1_rst_en", en1, 1'b1);

    rst = 1'b0;
    step();
    chk("post_rst_ready", load_ready, 1'b1);
    chk("post_rst_en", digit_en, 4'b0001);
    chk("n1_idle_en", en1, 1'b0);
    chk("n1_zero_seg", seg1, 7'b0000001);

    do_load(16'h12AF, 4'b0010, 1'b0);
    read_frame("f12af", {7'b0110000, 7'b1101101, 7'b1110111, 7'b1000111},
               4'b0010);

    repeat (5) step();
    do_load(16'h3456, 4'b0000, 1'b0);
    chk("pend_ready_low", load_ready, 1'b0);
    data_in = 16'h789C; dp_in = 4'b1000; load_valid = 1'b1;
    step();
    chk("third_blocked", load_ready, 1'b0);
    read_frame("f3456", {7'b1111001, 7'b0110011, 7'b1011011, 7'b1011111},
               4'b0000);
    load_valid = 1'b0;
    read_frame("f789c", {7'b1110000, 7'b1111111, 7'b1111011, 7'b1001110},
               4'b1000);

    do_load(16'h0070, 4'b0000, 1'b1);
    read_frame("blank70", {7'b0, 7'b0, 7'b1110000, 7'b1111110}, 4'b0000);
    do_load(16'h0000, 4'b0100, 1'b1);
    read_frame("blank00", {7'b0, 7'b0, 7'b0, 7'b1111110}, 4'b0100);

    for (int c = 0; c < 300; c++) begin
      load_valid = ($urandom_range(3) == 0);
      data_in = 16'($urandom);
      if ($urandom_range(3) == 0) data_in = data_in & 16'h00FF;
      dp_in = 4'($urandom);
      blank_lz = 1'($urandom);
      step();
    end
    load_valid = 1'b0;

    repeat (6) step();
    do_load(16'h5555, 4'b1111, 1'b0);
    step();
    rst = 1'b1;
    step();
    chk("midrst_seg", seg, 7'b0000000);
    chk("midrst_en", digit_en, 4'b0000);
    chk("midrst_ready", load_ready, 1'b0);
    rst = 1'b0;
    read_frame("postrst", {4{7'b1111110}}, 4'b0000);

    got1 = 0;
    data1 = 4'h8; dp1_in = 1'b0; valid1 = 1'b1;
    for (int c = 0; c < 40; c++) begin
      step();
      if (!ready1) begin
        got1 = 1;
        break;
      end
    end
    chk("n1_load", got1, 1);
    repeat (6) step();
    last = -1; per1 = 0; per2 = 0; rises = 0;
    pr = ready1;
    for (int c = 0; c < 60; c++) begin
      step();
      chk("n1_seg", seg1, 7'b0000000);
      chk("n1_en", en1, 1'b0);
      chk("n1_dp", dp1, 1'b1);
      if (ready1 && !pr) begin
        if (rises == 1) per1 = c - last;
        if (rises == 2) per2 = c - last;
        last = c;
        rises++;
      end
      pr = ready1;
      if (rises == 3) break;
    end
    valid1 = 1'b0;
    chk("n1_frame_period_a", per1, D);
    chk("n1_frame_period_b", per2, D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
